regfile_write_sched: RTL

Write-port scheduler for the 16 x 8-bit register file. It shares the file's single write port (`we3`/`wa3`/`wd3`) between two requesters:
- port 0: CPU write-back;
- port 1: game I/O / loader.

It also sequences a bulk clear of registers 1..15, automatically after reset and on demand. It sits between the requesters and the register file's write inputs; read ports are untouched.

---
 rtl/regfile_write_sched_if.sv | 42 ++++
 rtl/regfile_write_sched.sv | 100 ++++++++++
 2 files changed

// File: rtl/regfile_write_sched_if.sv
// Write-port bus between the two requesters, the clear control and the
// register file's single write port.
interface regfile_write_sched_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              ack0;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              ack1;

  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;

  // Requester / register-file side
  modport master (
    output clr_start,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  clr_busy, clr_done, ack0, ack1,
    input  we3, wa3, wd3
  );

  // Scheduler side
  modport slave (
    input  clr_start,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output clr_busy, clr_done, ack0, ack1,
    output we3, wa3, wd3
  );
endinterface

// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the 16 x 8 register file: arbitrates CPU
// write-back (port 0) and loader I/O (port 1) round-robin onto the single
// write port, and sequences a bulk clear of registers 1..15 after reset or
// on clr_start. Register 0 is hard zero and never written.
module regfile_write_sched #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_sched_if.slave  bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic              last;
  logic              we3_q;
  logic [ADDR_W-1:0] wa3_q;
  logic [DATA_W-1:0] wd3_q;
  logic              clr_done_q;

  logic              grant0;
  logic              grant1;
  logic              ack0;
  logic              ack1;

  // Round-robin: a lone request wins, on a tie the port that did not go last wins
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last);
    ack0   = (state == RUN) & ~bus.clr_start & grant0;
    ack1   = (state == RUN) & ~bus.clr_start & grant1;
  end

  // Clear sequencing, write issue and round-robin history; the edge that
  // accepts clr_start already issues register 1 so the clear spans 15 edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= (ADDR_W+1)'(1);
      last       <= 1'b1;
      we3_q      <= 1'b0;
      wa3_q      <= '0;
      wd3_q      <= '0;
      clr_done_q <= 1'b0;
    end else begin
      we3_q      <= 1'b0;
      clr_done_q <= 1'b0;
      case (state)
        CLEAR: begin
          if (cnt == (ADDR_W+1)'(NREGS)) begin
            state      <= RUN;
            clr_done_q <= 1'b1;
          end else begin
            we3_q <= 1'b1;
            wa3_q <= cnt[ADDR_W-1:0];
            wd3_q <= '0;
            cnt   <= cnt + (ADDR_W+1)'(1);
          end
        end
        RUN: begin
          if (bus.clr_start) begin
            state <= CLEAR;
            we3_q <= 1'b1;
            wa3_q <= ADDR_W'(1);
            wd3_q <= '0;
            cnt   <= (ADDR_W+1)'(2);
          end else if (ack0) begin
            last <= 1'b0;
            if (bus.req0_addr != '0) begin
              we3_q <= 1'b1;
              wa3_q <= bus.req0_addr;
              wd3_q <= bus.req0_data;
            end
          end else if (ack1) begin
            last <= 1'b1;
            if (bus.req1_addr != '0) begin
              we3_q <= 1'b1;
              wa3_q <= bus.req1_addr;
              wd3_q <= bus.req1_data;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.ack0     = ack0;
  assign bus.ack1     = ack1;
  assign bus.we3      = we3_q;
  assign bus.wa3      = wa3_q;
  assign bus.wd3      = wd3_q;
  assign bus.clr_busy = (state == CLEAR);
  assign bus.clr_done = clr_done_q;

endmodule
